// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arithmetic ops, shift-add multiply and
// restoring divide, both iterating one bit per clock over a shared
// hi/lo register pair.
module multicycle_alu #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             Sel,
  input  logic [WORD_LENGTH-1:0] A,
  input  logic [WORD_LENGTH-1:0] B,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_LENGTH-1:0] result_lo,
  output logic [WORD_LENGTH-1:0] result_hi,
  output logic                   carry,
  output logic                   ZeroFlag,
  output logic                   div_by_zero
);

  localparam int W  = WORD_LENGTH;
  localparam int SW = $clog2(W);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_NOT = 4'b0011;
  localparam logic [3:0] OP_NEG = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_SHH = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_SHR = 4'b1011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     sel_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   hi_q, lo_q;
  logic [CW-1:0]  cnt_q;
  logic           accept;
  logic           last_iter;

  logic [W:0]     msum;
  logic [W:0]     dshift, ddiff;
  logic [W:0]     add_w, sub_w;
  logic [W-1:0]   res_lo_d, res_hi_d;
  logic           carry_d, dbz_d;

  logic           busy_q, done_q, carry_q, zero_q, dbz_q;
  logic [W-1:0]   result_lo_q, result_hi_q;

  assign accept    = (state_q == IDLE) && start;
  assign last_iter = (cnt_q == CW'(W - 1));

  // Multiply step adds the multiplicand into the high word when the current
  // multiplier bit is set; divide step trial-subtracts the divisor from the
  // partial remainder with the next dividend bit shifted in.
  assign msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign dshift = {hi_q, lo_q[W-1]};
  assign ddiff  = dshift - {1'b0, b_q};
  assign add_w  = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w  = {1'b0, a_q} - {1'b0, b_q};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: iterative ops loop for W cycles, everything else goes straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) begin
        if (Sel == OP_MUL)                     state_d = MUL;
        else if (Sel == OP_DIV && B != '0)     state_d = DIV;
        else                                   state_d = DONE;
      end
      MUL:  if (last_iter) state_d = DONE;
      DIV:  if (last_iter) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result and flag values presented to the output registers in DONE
  always_comb begin
    res_lo_d = '0;
    res_hi_d = '0;
    carry_d  = 1'b0;
    dbz_d    = 1'b0;
    case (sel_q)
      OP_ADD: begin res_lo_d = add_w[W-1:0]; carry_d = add_w[W]; end
      OP_SUB: begin res_lo_d = sub_w[W-1:0]; carry_d = sub_w[W]; end
      OP_MUL: begin res_lo_d = lo_q; res_hi_d = hi_q; end
      OP_NOT: res_lo_d = ~a_q;
      OP_NEG: res_lo_d = -a_q;
      OP_AND: res_lo_d = a_q & b_q;
      OP_OR:  res_lo_d = a_q | b_q;
      OP_SHH: res_lo_d = b_q << (W / 2);
      OP_SHL: res_lo_d = b_q << a_q[SW-1:0];
      OP_SLT: res_lo_d = {{(W-1){1'b0}}, (a_q < b_q)};
      OP_DIV: begin
        if (b_q == '0) begin
          res_lo_d = '1;
          res_hi_d = a_q;
          dbz_d    = 1'b1;
        end else begin
          res_lo_d = lo_q;
          res_hi_d = hi_q;
        end
      end
      OP_SHR: res_lo_d = b_q >> a_q[SW-1:0];
      default: ;
    endcase
  end

  // Operand latch and shared multiply/divide iteration registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      sel_q <= Sel;
      a_q   <= A;
      b_q   <= B;
      hi_q  <= '0;
      lo_q  <= (Sel == OP_DIV) ? A : B;
      cnt_q <= '0;
    end else if (state_q == MUL) begin
      hi_q  <= msum[W:1];
      lo_q  <= {msum[0], lo_q[W-1:1]};
      cnt_q <= cnt_q + CW'(1);
    end else if (state_q == DIV) begin
      if (!ddiff[W]) begin
        hi_q <= ddiff[W-1:0];
        lo_q <= {lo_q[W-2:0], 1'b1};
      end else begin
        hi_q <= dshift[W-1:0];
        lo_q <= {lo_q[W-2:0], 1'b0};
      end
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Output registers: results/flags load only on the edge that raises done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      if (state_q == DONE) begin
        busy_q      <= 1'b0;
        result_lo_q <= res_lo_d;
        result_hi_q <= res_hi_d;
        carry_q     <= carry_d;
        zero_q      <= (res_lo_d == '0);
        dbz_q       <= dbz_d;
      end else if (accept) begin
        busy_q <= 1'b1;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = result_lo_q;
  assign result_hi   = result_hi_q;
  assign carry       = carry_q;
  assign ZeroFlag    = zero_q;
  assign div_by_zero = dbz_q;

endmodule
